// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - seven-segment pattern constants, decode helpers and sequence state type
package seg7_pkg;

   localparam logic [6:0] SEG7_D0    = 7'b0000001;
   localparam logic [6:0] SEG7_D1    = 7'b1001111;
   localparam logic [6:0] SEG7_D2    = 7'b0010010;
   localparam logic [6:0] SEG7_D3    = 7'b0000110;
   localparam logic [6:0] SEG7_D4    = 7'b1001100;
   localparam logic [6:0] SEG7_D5    = 7'b0100100;
   localparam logic [6:0] SEG7_D6    = 7'b0100000;
   localparam logic [6:0] SEG7_D7    = 7'b0001111;
   localparam logic [6:0] SEG7_D8    = 7'b0000000;
   localparam logic [6:0] SEG7_D9    = 7'b0000100;
   localparam logic [6:0] SEG7_BLANK = 7'b1111111;

   typedef enum logic [0:0] {
      SEQ_IDLE  = 1'b0,
      SEQ_TRACK = 1'b1
   } seq_state_t;

   typedef struct packed {
      logic       legal;
      logic [3:0] digit;
   } seg7_dec_t;

   // Blank is reported as not legal; callers separate it out before flagging errors.
   function automatic seg7_dec_t seg7_decode(input logic [6:0] pat);
      seg7_dec_t d;
      d.legal = 1'b1;
      d.digit = 4'd0;
      case (pat)
         SEG7_D0: d.digit = 4'd0;
         SEG7_D1: d.digit = 4'd1;
         SEG7_D2: d.digit = 4'd2;
         SEG7_D3: d.digit = 4'd3;
         SEG7_D4: d.digit = 4'd4;
         SEG7_D5: d.digit = 4'd5;
         SEG7_D6: d.digit = 4'd6;
         SEG7_D7: d.digit = 4'd7;
         SEG7_D8: d.digit = 4'd8;
         SEG7_D9: d.digit = 4'd9;
         default: d.legal = 1'b0;
      endcase
      return d;
   endfunction

   function automatic logic [3:0] seg7_next_digit(input logic [3:0] d);
      return (d == 4'd9) ? 4'd0 : d + 4'd1;
   endfunction

endpackage

// File: rtl/seg7_stab_filter.sv
// rtl/seg7_stab_filter.sv - pad synchronizer and stability filter producing one accept pulse per settled pattern
module seg7_stab_filter
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       en_i,
   input  logic [6:0] seg_i,
   output logic       accept,
   output logic [6:0] pattern
);

   localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

   logic [6:0] sync1, sync2, cand;
   logic [7:0] cnt, cnt_nxt;
   logic       fire;

   // cnt saturates at STABLE_N so a settled value fires exactly once.
   always_comb begin
      if (sync2 != cand)
         cnt_nxt = 8'd1;
      else if (cnt == STABLE_N)
         cnt_nxt = cnt;
      else
         cnt_nxt = cnt + 8'd1;
      fire = en_i && (cnt_nxt == STABLE_N) && ((sync2 != cand) || (cnt != STABLE_N))
             && (sync2 != pattern);
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         sync1   <= SEG7_BLANK;
         sync2   <= SEG7_BLANK;
         cand    <= SEG7_BLANK;
         cnt     <= 8'd0;
         pattern <= SEG7_BLANK;
         accept  <= 1'b0;
      end else begin
         sync1  <= seg_i;
         sync2  <= sync1;
         cand   <= sync2;
         accept <= fire;
         if (!en_i) begin
            cnt     <= 8'd0;
            pattern <= SEG7_BLANK;
         end else begin
            cnt <= cnt_nxt;
            if (fire)
               pattern <= sync2;
         end
      end
   end

endmodule

// File: rtl/seg7_pattern_rx.sv
// rtl/seg7_pattern_rx.sv - 7-seg bus monitor: decode, optional sequence check (SEG7_SEQ_CHECK_EN), event counters
module seg7_pattern_rx
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 16
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic [6:0]       seg_i,
   output logic [3:0]       digit_o,
   output logic             digit_valid_o,
   output logic             blank_o,
   output logic             err_code_o,
   output logic             err_seq_o,
   output logic [CNT_W-1:0] digit_count_o,
   output logic [CNT_W-1:0] err_count_o
);

   logic       accept;
   logic [6:0] acc_pat;
   seg7_dec_t  dec;
   logic       is_blank, valid_d, code_d, seq_d;

   seg7_stab_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .en_i     (en_i),
      .seg_i    (seg_i),
      .accept   (accept),
      .pattern  (acc_pat)
   );

   always_comb begin
      dec      = seg7_decode(acc_pat);
      is_blank = accept && (acc_pat == SEG7_BLANK);
      valid_d  = accept && dec.legal;
      code_d   = accept && !dec.legal && (acc_pat != SEG7_BLANK);
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         digit_o       <= 4'd0;
         blank_o       <= 1'b1;
         digit_valid_o <= 1'b0;
         err_code_o    <= 1'b0;
      end else begin
         digit_valid_o <= valid_d;
         err_code_o    <= code_d;
         if (valid_d) begin
            digit_o <= dec.digit;
            blank_o <= 1'b0;
         end else if (is_blank) begin
            blank_o <= 1'b1;
         end
      end
   end

`ifdef SEG7_SEQ_CHECK_EN
   seq_state_t state;
   logic [3:0] prev;

   always_comb begin
      seq_d = valid_d && (state == SEQ_TRACK) && (dec.digit != seg7_next_digit(prev));
   end

   // Mismatches re-synchronise on the received digit rather than flagging every later one.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state     <= SEQ_IDLE;
         prev      <= 4'd0;
         err_seq_o <= 1'b0;
      end else begin
         err_seq_o <= seq_d;
         if (!en_i) begin
            state <= SEQ_IDLE;
         end else if (valid_d) begin
            state <= SEQ_TRACK;
            prev  <= dec.digit;
         end else if (code_d) begin
            state <= SEQ_IDLE;
         end
      end
   end
`else
   assign seq_d     = 1'b0;
   assign err_seq_o = 1'b0;
`endif

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         digit_count_o <= '0;
         err_count_o   <= '0;
      end else if (clr_i) begin
         digit_count_o <= '0;
         err_count_o   <= '0;
      end else begin
         if (valid_d && (digit_count_o != '1))
            digit_count_o <= digit_count_o + CNT_W'(1);
         if ((code_d || seq_d) && (err_count_o != '1))
            err_count_o <= err_count_o + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_seg7_pattern_rx.sv
// tb/tb_seg7_pattern_rx.sv - directed table-driven bench for seg7_pattern_rx
module tb_seg7_pattern_rx;

`ifdef SEG7_SEQ_CHECK_EN
   localparam int SEQ_ON = 1;
`else
   localparam int SEQ_ON = 0;
`endif

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i;
   logic        en_i;
   logic        clr_i;
   logic [6:0]  seg_i;
   logic [3:0]  digit_o;
   logic        digit_valid_o;
   logic        blank_o;
   logic        err_code_o;
   logic        err_seq_o;
   logic [15:0] digit_count_o;
   logic [15:0] err_count_o;

   seg7_pattern_rx dut (
      .wb_clk_i      (wb_clk_i),
      .wb_rst_i      (wb_rst_i),
      .en_i          (en_i),
      .clr_i         (clr_i),
      .seg_i         (seg_i),
      .digit_o       (digit_o),
      .digit_valid_o (digit_valid_o),
      .blank_o       (blank_o),
      .err_code_o    (err_code_o),
      .err_seq_o     (err_seq_o),
      .digit_count_o (digit_count_o),
      .err_count_o   (err_count_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   typedef struct {
      logic [6:0] seg;
      int         exp_v;
      int         exp_d;
      int         exp_b;
      int         exp_c;
      int         exp_s;
   } vec_t;

   vec_t vecs [15];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   nv, nc, ns, fv;
   int   tv, tc, ts, tf;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // k-th sample is taken on the negedge after the k-th posedge following the drive.
   task automatic watch(input int n, output int v, output int c, output int s, output int first_v);
      v = 0; c = 0; s = 0; first_v = -1;
      for (int k = 0; k < n; k++) begin
         @(negedge wb_clk_i);
         if (digit_valid_o) begin
            v++;
            if (first_v < 0) first_v = k;
         end
         if (err_code_o) c++;
         if (err_seq_o)  s++;
      end
   endtask

   initial begin
      vecs[0]  = '{7'b0000001, 1, 0, 0, 0, 0};
      vecs[1]  = '{7'b1001111, 1, 1, 0, 0, 0};
      vecs[2]  = '{7'b0010010, 1, 2, 0, 0, 0};
      vecs[3]  = '{7'b0000110, 1, 3, 0, 0, 0};
      vecs[4]  = '{7'b1001100, 1, 4, 0, 0, 0};
      vecs[5]  = '{7'b0100100, 1, 5, 0, 0, 0};
      vecs[6]  = '{7'b0100000, 1, 6, 0, 0, 0};
      vecs[7]  = '{7'b0001111, 1, 7, 0, 0, 0};
      vecs[8]  = '{7'b0000000, 1, 8, 0, 0, 0};
      vecs[9]  = '{7'b0000100, 1, 9, 0, 0, 0};
      vecs[10] = '{7'b1111111, 0, 9, 1, 0, 0};
      vecs[11] = '{7'b0110110, 0, 9, 1, 1, 0};
      vecs[12] = '{7'b0000110, 1, 3, 0, 0, 0};
      vecs[13] = '{7'b0100100, 1, 5, 0, 0, SEQ_ON};
      vecs[14] = '{7'b0100000, 1, 6, 0, 0, 0};

      wb_rst_i = 1'b1;
      en_i     = 1'b1;
      clr_i    = 1'b0;
      seg_i    = 7'b1111111;
      repeat (3) @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      @(negedge wb_clk_i);
      chk("rst_digit", digit_o, 0);
      chk("rst_blank", blank_o, 1);
      chk("rst_pulses", {digit_valid_o, err_code_o, err_seq_o}, 0);
      chk("rst_dcount", digit_count_o, 0);
      chk("rst_ecount", err_count_o, 0);

      // Glitch shorter than the filter window, then a clean change with latency check.
      seg_i = 7'b0000001;
      watch(20, nv, nc, ns, fv);
      chk("g0_valid", nv, 1);
      chk("g0_digit", digit_o, 0);
      seg_i = 7'b1001111;
      watch(3, nv, nc, ns, fv);
      seg_i = 7'b0000001;
      watch(20, tv, tc, ts, tf);
      chk("glitch_events", nv + nc + ns + tv + tc + ts, 0);
      seg_i = 7'b1001111;
      watch(20, nv, nc, ns, fv);
      chk("g1_valid", nv, 1);
      chk("g1_latency", fv, 6);
      chk("g1_digit", digit_o, 1);
      chk("g1_seq", ns, 0);

      // Reset mid-filter while the pad returns to blank: nothing may follow.
      seg_i = 7'b0010010;
      watch(3, nv, nc, ns, fv);
      wb_rst_i = 1'b1;
      seg_i    = 7'b1111111;
      @(negedge wb_clk_i);
      chk("mid_rst_digit", digit_o, 0);
      chk("mid_rst_blank", blank_o, 1);
      chk("mid_rst_dcount", digit_count_o, 0);
      wb_rst_i = 1'b0;
      watch(20, nv, nc, ns, fv);
      chk("mid_rst_events", nv + nc + ns, 0);
      chk("mid_rst_ecount", err_count_o, 0);

      for (int i = 0; i < 15; i++) begin
         seg_i = vecs[i].seg;
         watch(20, nv, nc, ns, fv);
         chk($sformatf("v%0d_valid", i), nv, vecs[i].exp_v);
         chk($sformatf("v%0d_digit", i), digit_o, vecs[i].exp_d);
         chk($sformatf("v%0d_blank", i), blank_o, vecs[i].exp_b);
         chk($sformatf("v%0d_code", i), nc, vecs[i].exp_c);
         chk($sformatf("v%0d_seq", i), ns, vecs[i].exp_s);
         if (i == 9) begin
            chk("wrap_dcount", digit_count_o, 10);
            chk("wrap_ecount", err_count_o, 0);
         end
         if (i == 11) chk("code_ecount", err_count_o, 1);
      end
      chk("tbl_dcount", digit_count_o, 13);
      chk("tbl_ecount", err_count_o, 1 + SEQ_ON);

      // Clear lands on the same edge as a digit_valid pulse.
      seg_i = 7'b0001111;
      watch(6, nv, nc, ns, fv);
      chk("clr_early", nv, 0);
      clr_i = 1'b1;
      @(negedge wb_clk_i);
      chk("clr_valid", digit_valid_o, 1);
      chk("clr_digit", digit_o, 7);
      chk("clr_dcount", digit_count_o, 0);
      chk("clr_ecount", err_count_o, 0);
      clr_i = 1'b0;
      @(negedge wb_clk_i);
      chk("clr_after", digit_count_o + err_count_o, 0);

      // Disabled for 50 cycles with changing input, then enable on a steady 7.
      en_i = 1'b0;
      tv = 0; tc = 0; ts = 0;
      seg_i = 7'b0000000;  watch(10, nv, nc, ns, fv); tv += nv; tc += nc; ts += ns;
      seg_i = 7'b0110110;  watch(10, nv, nc, ns, fv); tv += nv; tc += nc; ts += ns;
      seg_i = 7'b0010010;  watch(10, nv, nc, ns, fv); tv += nv; tc += nc; ts += ns;
      seg_i = 7'b1111111;  watch(10, nv, nc, ns, fv); tv += nv; tc += nc; ts += ns;
      seg_i = 7'b0001111;  watch(10, nv, nc, ns, fv); tv += nv; tc += nc; ts += ns;
      chk("dis_valid", tv, 0);
      chk("dis_errs", tc + ts, 0);
      en_i = 1'b1;
      watch(20, nv, nc, ns, fv);
      chk("en_valid", nv, 1);
      chk("en_latency", fv, 4);
      chk("en_digit", digit_o, 7);
      chk("en_seq", ns, 0);
      chk("en_dcount", digit_count_o, 1);
      chk("en_ecount", err_count_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seg7_pattern_rx.md
# seg7_pattern_rx

Receive-side monitor for the user-project 7-segment display bus. It samples the active-low segment pattern driven on the user GPIOs, applies a synchronizer and stability filter, then decodes each settled pattern back to a BCD digit. It flags illegal patterns and, when compiled in, out-of-order counting. It sits in the user project area, fed by looped-back `mprj_io` inputs, so firmware and silicon bring-up can self-check the display driver without an external probe.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive identical synchronized samples required before a pattern is accepted; legal range 1–255.
- `CNT_W`, default 16: width of the event counters.

Ports:
- `wb_clk_i`  in  1  the single clock.
- `wb_rst_i`  in  1  asynchronous, active-high reset.
- `en_i`  in  1  enables acceptance.
- `clr_i`  in  1  synchronous clear of both counters.
- `seg_i`  in  7  raw pad pattern, active low, `{a,b,c,d,e,f,g}` with a = bit 6.
- `digit_o`  out  4  last accepted digit, 0–9.
- `digit_valid_o`  out  1  one-cycle pulse when a new digit is accepted.
- `blank_o`  out  1  level; the last accepted pattern is all-off (7'b1111111).
- `err_code_o`  out  1  one-cycle pulse when the accepted pattern is illegal.
- `err_seq_o`  out  1  one-cycle pulse on a sequence violation.
- `digit_count_o`  out  CNT_W  number of accepted digits, saturating.
- `err_count_o`  out  CNT_W  number of errors, saturating.

## Operation
- `seg_i` passes through a 2-flop synchronizer; no logic touches it before the synchronizer.
- **Stability filter:** the synchronized value must hold for `STABLE_CYCLES` consecutive cycles.
  - Any change restarts the count.
  - A stable value equal to the last accepted pattern is not re-accepted.
  - A glitch shorter than `STABLE_CYCLES` that returns to the last accepted pattern produces no event.
- **Decode table** (active low):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
- **Accepted legal digit:** update `digit_o`, pulse `digit_valid_o`, clear `blank_o`.
- **Accepted 1111111:** set `blank_o`; `digit_o` holds its value; no pulse.
- **Any other accepted pattern:** pulse `err_code_o`; `digit_o` and `blank_o` hold.
- **`en_i` low:**
  - the synchronizer keeps running;
  - the filter count is held at 0;
  - the last-accepted register is forced to 1111111;
  - the sequence FSM returns to IDLE.
  - After `en_i` rises, the current steady pattern is accepted after `STABLE_CYCLES`.
- **Sequence FSM** (present only with the macro):
  - IDLE: the first accepted digit goes to TRACK, with no check.
  - TRACK: expected digit = (prev + 1) mod 10, so 9 → 0 is legal.
    - Mismatch: pulse `err_seq_o`, stay in TRACK, adopt the received digit as the new prev.
    - Blank: no state change.
    - Code error: go to IDLE.
- **Counters:**
  - `digit_count_o` increments on each `digit_valid_o`.
  - `err_count_o` increments by 1 per cycle in which `err_code_o` or `err_seq_o` pulses (the two never coincide).
  - Both saturate at all-ones.
  - `clr_i` zeroes both and takes priority over a same-cycle increment.

## Timing
- Reset values:
  - `digit_o` = 0, `blank_o` = 1;
  - all pulses 0, both counters 0;
  - FSM in IDLE;
  - last-accepted register and synchronizer = 1111111.
- Latency: `seg_i` is stable before edge 0 → the pulse is high in the cycle after edge `STABLE_CYCLES`+2. With the default of 4, the pulse follows edge 6.
- All outputs are registered, and pulses last exactly one cycle.
- Minimum spacing between acceptances is `STABLE_CYCLES` cycles.
- Reset asserted mid-filter discards the candidate; no pulse is emitted.

## Configuration
- `SEG7_SEQ_CHECK_EN` defined: the sequence FSM and `err_seq_o` are compiled in.
- Undefined: no FSM is present, `err_seq_o` is tied to 0, and `err_count_o` counts code errors only.

## Structure
- Package `seg7_pkg` holds:
  - the ten digit-pattern constants;
  - the blank constant `SEG7_BLANK`;
  - the FSM state typedef (`SEQ_IDLE`, `SEQ_TRACK`).
- Sub-module `seg7_stab_filter` contains the synchronizer and stability counter. It takes `en_i` and outputs a one-cycle `accept` plus the 7-bit accepted pattern.
- The top level holds the decode, FSM and counters.

## Test plan
- Drive 0–9 in order, each held 20 cycles → ten `digit_valid_o` pulses with `digit_o` 0..9, `digit_count_o` = 10, `err_count_o` = 0; the 9 → 0 wrap raises no error.
- Hold 0000001, then pulse 1001111 for 3 cycles (`STABLE_CYCLES` = 4) → no event; the same value held 4 cycles → exactly one pulse with digit 1, arriving 6 edges after the change.
- Drive 1111111 → `blank_o` = 1, `digit_o` unchanged; drive 0110110 → `err_code_o` pulse, `err_count_o` = 1.
- With the macro: drive 3 then 5 → `err_seq_o` pulse; then 6 → no error. Without the macro: `err_seq_o` stays 0.
- Assert `wb_rst_i` for 1 cycle mid-filter → outputs return to reset values and no pulse follows; assert `clr_i` together with a `digit_valid_o` → counters read 0.
- With `en_i` low for 50 cycles → no pulses; raise `en_i` while the input is held at 7 → digit 7 is accepted after `STABLE_CYCLES` with no `err_seq_o`.
